// File: rtl/turbo_pkg.sv
// Turbo coder constants and QPP index helper shared by the interleaver files.
// Elaboration-time only: nothing here produces runtime logic.
// No flow control: pure constants and a constant function.
package turbo_pkg;

    localparam int K_L  = 6144;
    localparam int K_S  = 1056;
    localparam int F1_L = 263;
    localparam int F2_L = 480;
    localparam int F1_S = 17;
    localparam int F2_S = 66;

    // Pi(i) = (F1*i + F2*i^2) mod K, factored as ((F1 + F2*i mod K) mod K)*i mod K
    // so that no intermediate exceeds 2^26 while keeping 32-bit int arithmetic.
    function automatic int qpp_index(input int f1, input int f2, input int k, input int i);
        int lin;
        lin = (f1 + ((f2 * i) % k)) % k;
        return (lin * i) % k;
    endfunction

endpackage

// File: rtl/qpp_perm_net.sv
// Fixed QPP permutation network: dout[Pi(i)] = din[i] for i < K, upper bits tied 0.
// Latency: 0 (pure wiring, no logic).
// Backpressure: none.
module qpp_perm_net
    import turbo_pkg::*;
#(
    parameter int W  = K_L,
    parameter int K  = K_L,
    parameter int F1 = F1_L,
    parameter int F2 = F2_L
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // One constant wire per code bit; the QPP is a bijection so each output bit
    // in [0,K) has exactly one driver.
    for (genvar i = 0; i < K; i++) begin : g_map
        assign dout[qpp_index(F1, F2, K, i)] = din[i];
    end

    // Positions beyond the block size carry no code bits.
    if (K < W) begin : g_upper
        assign dout[W-1:K] = '0;
        wire unused_din_hi = ^din[W-1:K];
    end

endmodule

// File: rtl/qpp_coder_interleaver.sv
// QPP bit interleaver for K=6144 or K=1056, one full block per clock.
// Latency: 1 clock (registered output).
// Backpressure: none; every in_valid block is accepted and out_valid pulses for one cycle.
module qpp_coder_interleaver
    import turbo_pkg::*;
#(
    parameter int W = K_L
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         k_eq_6144,
    input  logic [W-1:0] cin,
    output logic [W-1:0] cout,
    output logic         out_valid
);

    logic [W-1:0] perm_l;
    logic [W-1:0] perm_s;
    logic [W-1:0] cout_d;
    logic [W-1:0] cout_q;
    logic         out_valid_d;
    logic         out_valid_q;

    qpp_perm_net #(.W(W), .K(K_L), .F1(F1_L), .F2(F2_L)) u_perm_l (
        .din  (cin),
        .dout (perm_l)
    );

    qpp_perm_net #(.W(W), .K(K_S), .F1(F1_S), .F2(F2_S)) u_perm_s (
        .din  (cin),
        .dout (perm_s)
    );

    // Select the network for the sampled block size; hold cout when idle.
    always_comb begin
        cout_d      = cout_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            cout_d      = k_eq_6144 ? perm_l : perm_s;
            out_valid_d = 1'b1;
        end
    end

    // Output register; reset wins over an incoming block.
    always_ff @(posedge clock) begin
        if (reset) begin
            cout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_qpp_coder_interleaver.sv
// Directed bench for qpp_coder_interleaver with hand-computed QPP positions.
module tb_qpp_coder_interleaver;

    localparam int W   = 6144;
    localparam int K_S = 1056;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         k_eq_6144;
    logic [W-1:0] cin;
    logic [W-1:0] cout;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    qpp_coder_interleaver dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .k_eq_6144 (k_eq_6144),
        .cin       (cin),
        .cout      (cout),
        .out_valid (out_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int first_set(input logic [W-1:0] v);
        for (int b = 0; b < W; b++)
            if (v[b]) return b;
        return -1;
    endfunction

    function automatic int ones_hi(input logic [W-1:0] v);
        logic [W-1:0] m;
        m = v;
        m[K_S-1:0] = '0;
        return $countones(m);
    endfunction

    function automatic int ones_lo(input logic [W-1:0] v);
        logic [K_S-1:0] m;
        m = v[K_S-1:0];
        return $countones(m);
    endfunction

    // Hand-computed Pi(i) for a few indices of each block size.
    int idx_s [4] = '{0, 1, 2, 1055};
    int pos_s [4] = '{0, 83, 298, 49};
    int idx_l [4] = '{0, 1, 2, 6143};
    int pos_l [4] = '{0, 743, 2446, 217};

    logic [W-1:0] seen;
    int           collide;
    int           p;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        k_eq_6144 = 1'b1;
        cin       = '1;

        // Reset beats a valid all-ones block.
        step();
        chk("rst cout", $countones(cout), 0);
        chk("rst vld", int'(out_valid), 0);
        reset = 1'b0;

        // K=1056 one-hot and inverted one-hot.
        k_eq_6144 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            cin = '0;
            cin[idx_s[t]] = 1'b1;
            step();
            chk($sformatf("s hot pos i=%0d", idx_s[t]), first_set(cout), pos_s[t]);
            chk($sformatf("s hot cnt i=%0d", idx_s[t]), $countones(cout), 1);
            chk("s hot vld", int'(out_valid), 1);

            cin = '1;
            cin[idx_s[t]] = 1'b0;
            step();
            chk($sformatf("s inv bit i=%0d", idx_s[t]), int'(cout[pos_s[t]]), 0);
            chk($sformatf("s inv lo i=%0d", idx_s[t]), ones_lo(cout), K_S - 1);
            chk($sformatf("s inv hi i=%0d", idx_s[t]), ones_hi(cout), 0);
        end

        // K=1056 all-ones: lower block full, upper forced to zero.
        cin = '1;
        step();
        chk("s ones lo", ones_lo(cout), K_S);
        chk("s ones hi", ones_hi(cout), 0);

        // K=6144 one-hot.
        k_eq_6144 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            cin = '0;
            cin[idx_l[t]] = 1'b1;
            step();
            chk($sformatf("l hot pos i=%0d", idx_l[t]), first_set(cout), pos_l[t]);
            chk($sformatf("l hot cnt i=%0d", idx_l[t]), $countones(cout), 1);
        end

        // Hold: idle cycle with new data keeps the last block.
        cin = '0;
        cin[1] = 1'b1;
        step();
        chk("hold pre pos", first_set(cout), 743);
        in_valid = 1'b0;
        cin = '0;
        cin[2] = 1'b1;
        k_eq_6144 = 1'b0;
        step();
        chk("hold pos", first_set(cout), 743);
        chk("hold cnt", $countones(cout), 1);
        chk("hold vld", int'(out_valid), 0);

        // Back-to-back with alternating mode.
        in_valid = 1'b1;
        cin = '0; cin[2] = 1'b1; k_eq_6144 = 1'b0;
        step();
        chk("b2b s2", first_set(cout), 298);
        chk("b2b vld", int'(out_valid), 1);
        cin = '0; cin[2] = 1'b1; k_eq_6144 = 1'b1;
        step();
        chk("b2b l2", first_set(cout), 2446);
        cin = '0; cin[6143] = 1'b1; k_eq_6144 = 1'b0;
        step();
        chk("b2b s ignored hi", $countones(cout), 0);
        cin = '0; cin[1] = 1'b1; k_eq_6144 = 1'b0;
        step();
        chk("b2b s1", first_set(cout), 83);

        // Mid-stream reset, then a clean block right after release.
        reset = 1'b1;
        cin = '0; cin[1] = 1'b1; k_eq_6144 = 1'b1;
        step();
        chk("mid rst cout", $countones(cout), 0);
        chk("mid rst vld", int'(out_valid), 0);
        reset = 1'b0;
        cin = '0; cin[1055] = 1'b1; k_eq_6144 = 1'b0;
        step();
        chk("post rst pos", first_set(cout), 49);
        chk("post rst vld", int'(out_valid), 1);

        // Exhaustive K=6144 sweep: every output bit hit exactly once.
        k_eq_6144 = 1'b1;
        seen      = '0;
        collide   = 0;
        for (int i = 0; i < W; i++) begin
            cin = '0;
            cin[i] = 1'b1;
            step();
            chk("sweep cnt", $countones(cout), 1);
            p = first_set(cout);
            if (p >= 0) begin
                if (seen[p]) collide++;
                seen[p] = 1'b1;
            end
        end
        chk("sweep cover", $countones(seen), W);
        chk("sweep collide", collide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpp_coder_interleaver.md
Name: qpp_coder_interleaver

Overview:
- Registered quadratic-permutation-polynomial (QPP) bit interleaver for the turbo coder datapath.
- Takes a full 6144-bit code block in parallel and permutes it for one of two block sizes, K=6144 or K=1056.
- Sits between the block buffer and the second constituent encoder; output is registered, one block per clock.

Parameters:
- W, 6144, bus width; also the large block size K_L.
- K_S, 1056, small block size.
- F1_L, 263, linear coefficient for K_L.
- F2_L, 480, quadratic coefficient for K_L.
- F1_S, 17, linear coefficient for K_S.
- F2_S, 66, quadratic coefficient for K_S.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  cin/k_eq_6144 qualify this cycle.
- k_eq_6144  input  1  1: K=6144 permutation; 0: K=1056 permutation.
- cin  input  W  input block; bit i is code bit i.
- cout  output  W  interleaved block.
- out_valid  output  1  cout holds a freshly interleaved block.

Behaviour:
- Permutation: Π_K(i) = (F1·i + F2·i²) mod K.
  - Output position Π_K(i) receives input bit i: cout[Π_K(i)] = cin[i] for 0 ≤ i < K.
- K=6144 (k_eq_6144=1): all 6144 bits permuted with F1_L/F2_L.
- K=1056 (k_eq_6144=0): bits 0..1055 permuted with F1_S/F2_S.
  - cout[1056..6143] forced to 0.
  - cin[1056..6143] ignored.
- Index arithmetic is resolved at elaboration as constant wiring; there are no runtime multipliers.
  - Compute Π_K(i) as (((F1 + (F2·i mod K)) mod K)·i) mod K.
  - This keeps every intermediate below 2^26 and avoids 32-bit overflow; the naive F2·i² reaches about 1.8e10.
- Datapath: two fixed permutation networks (large, small) feed a per-bit 2:1 mux selected by k_eq_6144, then the output register.
- Latency: exactly 1 clock.
  - On a rising edge with in_valid=1: cout ← permuted cin, out_valid ← 1.
  - On a rising edge with in_valid=0: cout holds its previous value, out_valid ← 0.
- k_eq_6144 is sampled on the same edge as cin; changing it between blocks has no effect on a block already registered.
- Reset, on a rising edge with reset=1 (reset takes priority over in_valid):
  - cout ← 0, out_valid ← 0.
  - Reset mid-stream discards the in-flight block.
- Throughput: one block per cycle, no backpressure, no internal state beyond the output register.
- Both mappings are bijections on [0,K); no two input bits drive the same output bit.

Decomposition:
- Shared package turbo_pkg:
  - K_L=6144, K_S=1056, F1/F2 constants for both sizes.
  - A constant function qpp_index(f1, f2, k, i) implementing the overflow-safe formula.
- One natural sub-module, qpp_perm_net.
  - Parameters K, F1, F2; combinational; input W, output W.
  - Generate-loop wiring; bits ≥ K tied to 0.
  - Instantiated twice, large and small; top level adds the mux and register.

Test Plan:
- Reset: assert reset with in_valid=1 and cin all-ones → next edge cout=0, out_valid=0.
- K=1056, single-hot sweep: cin one-hot at i, in_valid=1 → one cycle later cout is one-hot at Π(i).
  - i=0 → cout[0], i=1 → cout[83], i=2 → cout[298], i=1055 → cout[49].
  - Repeat with inverted data (all-ones except bit i) to check the zero mapping.
- K=1056 upper bits: cin all-ones, k_eq_6144=0 → cout[1055:0] all ones, cout[6143:1056] all zero.
- K=6144, single-hot sweep: i=0 → cout[0], i=1 → cout[743], i=2 → cout[2446], i=6143 → cout[217].
  - Full exhaustive sweep of all i confirms a bijection: each output bit is set exactly once.
- Hold/valid: a block is followed by in_valid=0 with new cin → cout unchanged, out_valid drops to 0.
  - Back-to-back blocks with alternating k_eq_6144 each map per their own sampled mode.
- Mid-stream reset: reset asserted during a valid stream → cout=0 next edge; the first block after reset release is correct with 1-cycle latency.
